// File: rtl/buzzer_arbiter_if.sv
// Control and result bundle between a quiz-game host and the buzzer arbiter.
// The master side arms/acks rounds; the slave side reports the locked result.
interface buzzer_arbiter_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int TS_WIDTH    = 32
);
  localparam int ID_W = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                   arm;
  logic                   ack;
  logic [TS_WIDTH-1:0]    timeout_cycles;
  logic [1:0]             state;
  logic                   result_valid;
  logic [ID_W-1:0]        winner_id;
  logic [NUM_PLAYERS-1:0] winner_onehot;
  logic [TS_WIDTH-1:0]    reaction_time;
  logic                   tie;
  logic                   timed_out;
  logic [NUM_PLAYERS-1:0] disq;
  logic                   irq;

  modport master (
    output arm, ack, timeout_cycles,
    input  state, result_valid, winner_id, winner_onehot, reaction_time,
           tie, timed_out, disq, irq
  );

  modport slave (
    input  arm, ack, timeout_cycles,
    output state, result_valid, winner_id, winner_onehot, reaction_time,
           tie, timed_out, disq, irq
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// First-press buzzer arbiter: synchronise and debounce player buttons, then
// lock the lowest-index eligible press (or a timeout) once per armed round.
module buzzer_arbiter #(
  parameter int NUM_PLAYERS     = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TS_WIDTH        = 32,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_PLAYERS-1:0] buttons_export,
  output logic [NUM_PLAYERS-1:0] debounced,
  buzzer_arbiter_if.slave        bus
);
  localparam int ID_W  = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_PLAYERS-1:0] raw, sync1, sync2, deb, deb_q;
  logic [CNT_W-1:0]       db_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] press, eligible, disq_q, onehot_low;
  logic [TS_WIDTH-1:0]    timer;
  logic [ID_W-1:0]        low_id;
  logic                   multi, timeout_hit;
  logic                   load_round, lock_press, lock_timeout, clear_all;

  logic [ID_W-1:0]        win_id_q;
  logic [NUM_PLAYERS-1:0] win_onehot_q;
  logic [TS_WIDTH-1:0]    rt_q;
  logic                   tie_q, timed_out_q, irq_q;

  assign raw = (ACTIVE_LOW != 0) ? ~buttons_export : buttons_export;

  // Synchroniser and per-channel debounce; any bounce restarts that channel's count.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      // NOTE: the counter array is small and must read as zero after reset, so
      // it is cleared element by element rather than left uninitialised like RAM.
      for (int i = 0; i < NUM_PLAYERS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press       = deb & ~deb_q;
  assign eligible    = (state_q == ARMED) ? (press & ~disq_q) : '0;
  assign onehot_low  = eligible & (~eligible + NUM_PLAYERS'(1));
  assign multi       = |(eligible & (eligible - NUM_PLAYERS'(1)));
  assign timeout_hit = (state_q == ARMED) && (bus.timeout_cycles != '0) &&
                       (timer == bus.timeout_cycles - TS_WIDTH'(1));

  always_comb begin
    low_id = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Priority inside a round: ack, then arm (restart), then a press, then timeout.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave a value unassigned and infer a latch.
    state_d      = state_q;
    load_round   = 1'b0;
    lock_press   = 1'b0;
    lock_timeout = 1'b0;
    clear_all    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.arm && !bus.ack) begin
          state_d    = ARMED;
          load_round = 1'b1;
        end
      end
      ARMED: begin
        if (bus.ack) begin
          state_d   = IDLE;
          clear_all = 1'b1;
        end else if (bus.arm) begin
          load_round = 1'b1;
        end else if (|eligible) begin
          state_d    = LOCKED;
          lock_press = 1'b1;
        end else if (timeout_hit) begin
          state_d      = LOCKED;
          lock_timeout = 1'b1;
        end
      end
      LOCKED: begin
        if (bus.ack) begin
          state_d   = IDLE;
          clear_all = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      timer        <= '0;
      disq_q       <= '0;
      win_id_q     <= '0;
      win_onehot_q <= '0;
      rt_q         <= '0;
      tie_q        <= 1'b0;
      timed_out_q  <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      irq_q <= lock_press | lock_timeout;

      // A disqualified player regains eligibility once their button is released.
      if (clear_all)       disq_q <= '0;
      else if (load_round) disq_q <= deb;
      else                 disq_q <= disq_q & deb;

      if (load_round)                               timer <= '0;
      else if (state_q == ARMED && timer != '1)     timer <= timer + TS_WIDTH'(1);

      if (lock_press) begin
        win_id_q     <= low_id;
        win_onehot_q <= onehot_low;
        rt_q         <= timer;
        tie_q        <= multi;
        timed_out_q  <= 1'b0;
      end else if (lock_timeout) begin
        win_id_q     <= '0;
        win_onehot_q <= '0;
        rt_q         <= timer;
        tie_q        <= 1'b0;
        timed_out_q  <= 1'b1;
      end else if (clear_all) begin
        win_id_q     <= '0;
        win_onehot_q <= '0;
        rt_q         <= '0;
        tie_q        <= 1'b0;
        timed_out_q  <= 1'b0;
      end
    end
  end

  assign debounced         = deb;
  assign bus.state         = state_q;
  assign bus.result_valid  = (state_q == LOCKED);
  assign bus.winner_id     = win_id_q;
  assign bus.winner_onehot = win_onehot_q;
  assign bus.reaction_time = rt_q;
  assign bus.tie           = tie_q;
  assign bus.timed_out     = timed_out_q;
  assign bus.disq          = disq_q;
  assign bus.irq           = irq_q;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench: directed round scenarios plus randomized buttons/arm/ack,
// all compared every cycle against a window-based behavioural model.
module tb_buzzer_arbiter;
  localparam int NP   = 4;
  localparam int DEB  = 4;
  localparam int TSW  = 8;
  localparam int TMAX = (1 << TSW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] buttons;
  logic [NP-1:0] debounced;

  buzzer_arbiter_if #(.NUM_PLAYERS(NP), .TS_WIDTH(TSW)) bus ();

  buzzer_arbiter #(
    .NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DEB), .TS_WIDTH(TSW), .ACTIVE_LOW(0)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .buttons_export(buttons),
    .debounced     (debounced),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: debounced level flips when the last DEB synchronised samples
  // (raw delayed two edges) all disagree with it; rounds follow the rule list.
  logic [NP-1:0] hist [0:DEB];
  logic [NP-1:0] m_deb, m_deb_prev, m_disq, m_onehot;
  int            m_state, m_timer, m_win, m_rt;
  bit            m_tie, m_to, m_irq;

  task automatic model_step();
    logic [NP-1:0] press, elig, next_disq, new_deb;
    bit            all_diff;
    int            lo;
    int            tmo;
    if (rst) begin
      m_state = 0; m_timer = 0; m_disq = '0; m_deb = '0; m_deb_prev = '0;
      m_win = 0; m_onehot = '0; m_rt = 0; m_tie = 0; m_to = 0; m_irq = 0;
      for (int k = 0; k <= DEB; k++) hist[k] = '0;
      return;
    end
    tmo       = int'(bus.timeout_cycles);
    press     = m_deb & ~m_deb_prev;
    elig      = press & ~m_disq;
    next_disq = m_disq & m_deb;
    m_irq     = 0;
    case (m_state)
      0: if (!bus.ack && bus.arm) begin
        m_state = 1; m_timer = 0; next_disq = m_deb;
      end
      1: begin
        if (bus.ack) begin
          m_state = 0; next_disq = '0;
        end else if (bus.arm) begin
          m_timer = 0; next_disq = m_deb;
        end else if (elig != '0) begin
          lo = -1;
          for (int i = 0; i < NP; i++) if (elig[i] && lo < 0) lo = i;
          m_win = lo; m_onehot = NP'(1) << lo; m_tie = ($countones(elig) > 1);
          m_rt = m_timer; m_to = 0; m_state = 2; m_irq = 1;
        end else if (tmo != 0 && m_timer == tmo - 1) begin
          m_win = 0; m_onehot = '0; m_tie = 0; m_rt = tmo - 1; m_to = 1;
          m_state = 2; m_irq = 1;
        end else if (m_timer < TMAX) begin
          m_timer++;
        end
      end
      2: if (bus.ack) begin
        m_state = 0; m_win = 0; m_onehot = '0; m_rt = 0; m_tie = 0; m_to = 0;
        next_disq = '0;
      end
      default: m_state = 0;
    endcase
    m_disq = next_disq;

    new_deb = m_deb;
    for (int i = 0; i < NP; i++) begin
      all_diff = 1;
      for (int k = 1; k <= DEB; k++) if (hist[k][i] == m_deb[i]) all_diff = 0;
      if (all_diff) new_deb[i] = ~m_deb[i];
    end
    for (int k = DEB; k >= 1; k--) hist[k] = hist[k-1];
    hist[0]    = buttons;
    m_deb_prev = m_deb;
    m_deb      = new_deb;
  endtask

  task automatic compare_all();
    check("state",         32'(bus.state),         32'(m_state));
    check("result_valid",  32'(bus.result_valid),  32'(m_state == 2));
    check("winner_id",     32'(bus.winner_id),     32'(m_win));
    check("winner_onehot", 32'(bus.winner_onehot), 32'(m_onehot));
    check("reaction_time", 32'(bus.reaction_time), 32'(m_rt));
    check("tie",           32'(bus.tie),           32'(m_tie));
    check("timed_out",     32'(bus.timed_out),     32'(m_to));
    check("disq",          32'(bus.disq),          32'(m_disq));
    check("irq",           32'(bus.irq),           32'(m_irq));
    check("debounced",     32'(debounced),         32'(m_deb));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
  endtask

  task automatic wait_lock(input int max_cycles);
    int n = 0;
    while (!bus.result_valid && n < max_cycles) begin
      step(); n++;
    end
    if (!bus.result_valid) check("wait_lock_expired", 32'd0, 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; buttons = '0;
    bus.arm = 1'b0; bus.ack = 1'b0; bus.timeout_cycles = '0;
    repeat (3) step();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_rv",    32'(bus.result_valid), 32'd0);
    check("rst_deb",   32'(debounced), 32'd0);
    check("rst_irq",   32'(bus.irq), 32'd0);
    rst = 1'b0;
    step();

    // Player 2 pressed at timer 10: locks with timer 10 + sync(2) + debounce(4).
    pulse_arm();
    repeat (10) step();
    buttons = 4'b0100;
    repeat (6) step();
    check("t1_still_armed", 32'(bus.state), 32'd1);
    step();
    check("t1_state",  32'(bus.state), 32'd2);
    check("t1_id",     32'(bus.winner_id), 32'd2);
    check("t1_onehot", 32'(bus.winner_onehot), 32'b0100);
    check("t1_rt",     32'(bus.reaction_time), 32'd16);
    check("t1_irq",    32'(bus.irq), 32'd1);
    step();
    check("t1_irq_once", 32'(bus.irq), 32'd0);
    check("t1_hold_id",  32'(bus.winner_id), 32'd2);
    buttons = '0;
    repeat (8) step();
    pulse_ack();
    check("t1_ack_state",  32'(bus.state), 32'd0);
    check("t1_ack_onehot", 32'(bus.winner_onehot), 32'd0);
    check("t1_ack_rt",     32'(bus.reaction_time), 32'd0);

    // Simultaneous presses: lowest index wins with tie flagged.
    pulse_arm();
    repeat (5) step();
    buttons = 4'b1010;
    wait_lock(20);
    check("t2_id",     32'(bus.winner_id), 32'd1);
    check("t2_tie",    32'(bus.tie), 32'd1);
    check("t2_onehot", 32'(bus.winner_onehot), 32'b0010);
    buttons = '0;
    repeat (8) step();
    pulse_ack();

    // Player 0 held at arm is disqualified until released.
    buttons = 4'b0001;
    repeat (8) step();
    pulse_arm();
    check("t3_disq_arm", 32'(bus.disq), 32'b0001);
    repeat (10) step();
    check("t3_no_win_held", 32'(bus.state), 32'd1);
    buttons = '0;
    repeat (8) step();
    check("t3_disq_clear", 32'(bus.disq), 32'd0);
    buttons = 4'b1000;
    step();
    buttons = 4'b1001;
    wait_lock(20);
    check("t3_id",  32'(bus.winner_id), 32'd3);
    check("t3_tie", 32'(bus.tie), 32'd0);
    buttons = '0;
    repeat (8) step();
    pulse_ack();

    // Timeout of 20 cycles with no press.
    bus.timeout_cycles = TSW'(20);
    pulse_arm();
    repeat (19) step();
    check("t4_armed", 32'(bus.state), 32'd1);
    step();
    check("t4_state",  32'(bus.state), 32'd2);
    check("t4_to",     32'(bus.timed_out), 32'd1);
    check("t4_rt",     32'(bus.reaction_time), 32'd19);
    check("t4_onehot", 32'(bus.winner_onehot), 32'd0);
    check("t4_irq",    32'(bus.irq), 32'd1);
    pulse_ack();

    // Press arriving in the timeout cycle wins.
    pulse_arm();
    repeat (13) step();
    buttons = 4'b0010;
    repeat (6) step();
    check("t4b_armed", 32'(bus.state), 32'd1);
    step();
    check("t4b_to", 32'(bus.timed_out), 32'd0);
    check("t4b_id", 32'(bus.winner_id), 32'd1);
    check("t4b_rt", 32'(bus.reaction_time), 32'd19);
    buttons = '0;
    repeat (8) step();
    pulse_ack();
    bus.timeout_cycles = '0;

    // Timeout disabled: timer saturates at all-ones.
    pulse_arm();
    repeat (300) step();
    check("t5_armed", 32'(bus.state), 32'd1);
    buttons = 4'b0100;
    wait_lock(20);
    check("t5_rt_sat", 32'(bus.reaction_time), 32'(TMAX));
    buttons = '0;
    repeat (8) step();
    pulse_ack();

    // Two-cycle glitch never reaches the debounced level.
    buttons = 4'b0100;
    repeat (2) step();
    buttons = '0;
    repeat (10) step();
    check("t6_glitch", 32'(debounced), 32'd0);
    pulse_arm();
    repeat (3) step();
    bus.arm = 1'b1; bus.ack = 1'b1;
    step();
    bus.arm = 1'b0; bus.ack = 1'b0;
    check("t6_ack_prio", 32'(bus.state), 32'd0);
    check("t6_no_irq",   32'(bus.irq), 32'd0);

    // Reset mid-round, with a button held through reset release.
    pulse_arm();
    repeat (5) step();
    rst = 1'b1; buttons = 4'b0010;
    step();
    rst = 1'b0;
    check("t7_state", 32'(bus.state), 32'd0);
    check("t7_disq",  32'(bus.disq), 32'd0);
    check("t7_irq",   32'(bus.irq), 32'd0);
    repeat (5) step();
    check("t7_deb_early", 32'(debounced), 32'd0);
    step();
    check("t7_deb_held", 32'(debounced), 32'b0010);
    buttons = '0;
    repeat (8) step();

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) if ($urandom_range(0, 11) == 0) buttons[i] = ~buttons[i];
      bus.arm = ($urandom_range(0, 19) == 0);
      bus.ack = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0)
        bus.timeout_cycles = ($urandom_range(0, 3) == 0) ? '0 : TSW'($urandom_range(3, 60));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
